vector_wb_queue: RTL and testbench

//   Writeback queue directly downstream of vector_alu. Captures each 128-bit ALU

---
 rtl/vector_wb_queue.sv | 113 +++++++++++
 tb/tb_vector_wb_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_wb_queue.sv
// Writeback queue between vector_alu and the vector register file write port.
// Results are buffered in order in a circular buffer and drained whenever the
// VRF arbiter grants the write port. Decode can ask whether a source register
// still has a write outstanding, so it can stall on RAW hazards.
module vector_wb_queue #(
  parameter int WIDTH      = 128,
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [REG_ADDR_W-1:0]        in_rd,
  input  logic                         flush,
  input  logic                         vrf_grant,
  output logic                         vrf_we,
  output logic [REG_ADDR_W-1:0]        vrf_waddr,
  output logic [WIDTH-1:0]             vrf_wdata,
  input  logic [REG_ADDR_W-1:0]        rs1_addr,
  input  logic [REG_ADDR_W-1:0]        rs2_addr,
  output logic                         rs1_pend,
  output logic                         rs2_pend,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0]      data_q [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push;
  logic                  pop;

  // Handshake and head-of-queue outputs; a pop never frees space for a same-cycle push
  always_comb begin
    in_ready  = (count_q < DEPTH_C);
    vrf_we    = (count_q != '0) && vrf_grant && !flush;
    push      = in_valid && in_ready && !flush;
    pop       = vrf_we;
    vrf_waddr = rd_q[rd_ptr_q];
    vrf_wdata = data_q[rd_ptr_q];
    count     = count_q;
  end

  // Next-state for pointers, occupancy and per-entry valid bits; flush wins over everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d          = rd_ptr_q + 1'b1;
        valid_d[rd_ptr_q] = 1'b0;
      end
      if (push) begin
        wr_ptr_d          = wr_ptr_q + 1'b1;
        valid_d[wr_ptr_q] = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // RAW hazard lookup over valid entries only; the incoming result is not visible yet
  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == rs1_addr)) rs1_pend = 1'b1;
      if (valid_q[i] && (rd_q[i] == rs2_addr)) rs2_pend = 1'b1;
    end
  end

  // Control state register; reset discards everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Entry payload storage; contents are qualified by valid_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= in_data;
      rd_q[wr_ptr_q]   <= in_rd;
    end
  end

endmodule

// File: tb/tb_vector_wb_queue.sv
// Directed testbench for vector_wb_queue: push/drain ordering, full queue,
// pointer wrap with concurrent push/pop, hazard lookup, flush and async reset.
module tb_vector_wb_queue;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   in_rd;
  logic         flush;
  logic         vrf_grant;
  logic         vrf_we;
  logic [3:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic [3:0]   rs1_addr;
  logic [3:0]   rs2_addr;
  logic         rs1_pend;
  logic         rs2_pend;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_rd [8] = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

  vector_wb_queue #(.WIDTH(128), .DEPTH(4), .REG_ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rd     (in_rd),
    .flush     (flush),
    .vrf_grant (vrf_grant),
    .vrf_we    (vrf_we),
    .vrf_waddr (vrf_waddr),
    .vrf_wdata (vrf_wdata),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .count     (count)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct recognisable payload per destination register
  function automatic logic [127:0] make_data(input logic [3:0] rd);
    return {4{28'hC0FFEE0, rd}};
  endfunction

  task automatic applyStimulus(input logic valid, input logic [3:0] rd,
                               input logic [127:0] data, input logic grant,
                               input logic flsh);
    in_valid  = valid;
    in_rd     = rd;
    in_data   = data;
    vrf_grant = grant;
    flush     = flsh;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = 4'd0;
    rs2_addr = 4'd0;
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_vrf_we", vrf_we, 0);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_rs1_pend", rs1_pend, 0);
    checkOutput("reset_rs2_pend", rs2_pend, 0);
    step();
    step();
    rst_n = 1'b1;

    // Single push with grant held: write appears the cycle after the push
    rs1_addr = 4'd3;
    applyStimulus(1'b1, 4'd3, {128{1'b1}}, 1'b1, 1'b0);
    checkOutput("t1_no_bypass_we", vrf_we, 0);
    checkOutput("t1_incoming_not_pending", rs1_pend, 0);
    step();
    applyStimulus(1'b0, 4'd0, '0, 1'b1, 1'b0);
    checkOutput("t1_count1", count, 1);
    checkOutput("t1_we", vrf_we, 1);
    checkOutput("t1_waddr", vrf_waddr, 3);
    checkOutput("t1_wdata", vrf_wdata, {128{1'b1}});
    checkOutput("t1_pend_head", rs1_pend, 1);
    step();
    checkOutput("t1_count0", count, 0);
    checkOutput("t1_we_idle", vrf_we, 0);

    // Fill to DEPTH with no grant, then a fifth push must be ignored
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'(i), make_data(4'(i)), 1'b0, 1'b0);
      step();
    end
    checkOutput("t2_full_count", count, 4);
    checkOutput("t2_full_ready", in_ready, 0);
    applyStimulus(1'b1, 4'd15, make_data(4'd15), 1'b0, 1'b0);
    step();
    checkOutput("t2_fifth_ignored", count, 4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 4'd0, '0, 1'b1, 1'b0);
      checkOutput("t2_drain_we", vrf_we, 1);
      checkOutput("t2_drain_waddr", vrf_waddr, 4'(i));
      checkOutput("t2_drain_wdata", vrf_wdata, make_data(4'(i)));
      step();
    end
    checkOutput("t2_empty", count, 0);

    // Two resident entries, then six cycles of simultaneous push and pop
    applyStimulus(1'b1, 4'd10, make_data(4'd10), 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'd11, make_data(4'd11), 1'b0, 1'b0);
    step();
    checkOutput("t3_count2", count, 2);
    for (int j = 0; j < 6; j++) begin
      applyStimulus(1'b1, 4'(j), make_data(4'(j)), 1'b1, 1'b0);
      checkOutput("t3_pp_we", vrf_we, 1);
      checkOutput("t3_pp_waddr", vrf_waddr, exp_rd[j]);
      checkOutput("t3_pp_wdata", vrf_wdata, make_data(exp_rd[j]));
      step();
      checkOutput("t3_pp_count", count, 2);
    end
    for (int j = 6; j < 8; j++) begin
      applyStimulus(1'b0, 4'd0, '0, 1'b1, 1'b0);
      checkOutput("t3_tail_waddr", vrf_waddr, exp_rd[j]);
      checkOutput("t3_tail_wdata", vrf_wdata, make_data(exp_rd[j]));
      step();
    end
    checkOutput("t3_empty", count, 0);

    // Hazard query: rd=5 then rd=9 queued
    rs1_addr = 4'd9;
    rs2_addr = 4'd7;
    applyStimulus(1'b1, 4'd5, make_data(4'd5), 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'd9, make_data(4'd9), 1'b0, 1'b0);
    checkOutput("t4_rs1_incoming_excluded", rs1_pend, 0);
    step();
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 1'b0);
    checkOutput("t4_rs1_pend", rs1_pend, 1);
    checkOutput("t4_rs2_not_pend", rs2_pend, 0);
    rs2_addr = 4'd5;
    applyStimulus(1'b0, 4'd0, '0, 1'b1, 1'b0);
    checkOutput("t4_head_popping_pend", rs2_pend, 1);
    step();
    checkOutput("t4_rs2_cleared", rs2_pend, 0);
    checkOutput("t4_rs1_still", rs1_pend, 1);
    step();
    applyStimulus(1'b0, 4'd0, '0, 1'b0, 1'b0);
    checkOutput("t4_rs1_cleared", rs1_pend, 0);
    checkOutput("t4_empty", count, 0);

    // Flush with push and grant active in the same cycle
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 4'(i), make_data(4'(i)), 1'b0, 1'b0);
      step();
    end
    rs1_addr = 4'd1;
    rs2_addr = 4'd6;
    applyStimulus(1'b1, 4'd6, make_data(4'd6), 1'b1, 1'b1);
    checkOutput("t5_count3", count, 3);
    checkOutput("t5_flush_we", vrf_we, 0);
    step();
    applyStimulus(1'b0, 4'd0, '0, 1'b1, 1'b0);
    checkOutput("t5_count0", count, 0);
    checkOutput("t5_rs1_pend", rs1_pend, 0);
    checkOutput("t5_rs2_pend_dropped", rs2_pend, 0);
    checkOutput("t5_ready", in_ready, 1);
    checkOutput("t5_we_after", vrf_we, 0);

    // Asynchronous reset in the middle of a cycle with a write pending
    applyStimulus(1'b1, 4'd8, make_data(4'd8), 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 4'd1, make_data(4'd1), 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 4'd0, '0, 1'b1, 1'b0);
    checkOutput("t6_count2", count, 2);
    checkOutput("t6_we_before", vrf_we, 1);
    checkOutput("t6_pend_before", rs1_pend, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_we", vrf_we, 0);
    checkOutput("t6_async_count", count, 0);
    checkOutput("t6_async_pend", rs1_pend, 0);
    checkOutput("t6_async_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("t6_post_count", count, 0);
    checkOutput("t6_post_we", vrf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
